uart_rx_word: RTL
=================

// Module: uart_rx_word
// PURPOSE
//  Receive end of the 16-bit word UART link. Deserialises two back-to-back 8N1 frames
//  (first frame = bits [15:8], second = [7:0], each LSB first) into one 16-bit word.
//  Sits on the FPGA serial input; feeds the I2C monitor command/config path.
// PARAMETERS
//  BAUD_RATE    115_200     line bit rate
//  CLOCK_RATE   27_000_000  i_clk frequency, Hz; CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE (integer divide)
//  GAP_BITS     4           inter-byte timeout in bit periods (used only with UART_RX_TIMEOUT_EN)
// PORTS
//  i_clk        in   1   system clock
//  i_rst        in   1   asynchronous, active-high reset
//  i_Rx_Serial  in   1   asynchronous serial line, idle high
//  o_Rx_Word    out  16  last complete word; held until next word completes
//  o_Rx_Valid   out  1   one-cycle pulse: o_Rx_Word updated this cycle
//  o_Rx_Busy    out  1   high from first start-bit detect until word done or aborted
//  o_Frame_Err  out  1   one-cycle pulse: stop bit sampled low (or gap timeout)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte index 0, counters 0, synchroniser FFs = 1.
//  i_Rx_Serial passes through 2-FF synchroniser; all decisions use synchronised bit.
//  States: IDLE -> START -> DATA -> STOP -> IDLE (byte 0) / DONE (byte 1) -> IDLE.
//  IDLE: falling edge (sync 1->0) -> START, counter cleared, o_Rx_Busy=1.
//  START: at count CLKS_PER_BIT/2 - 1 sample; low -> DATA, counter 0; high -> false
//   start, back to IDLE, byte index and partial word unchanged.
//  DATA: sample every CLKS_PER_BIT clocks (mid-bit); 8 bits LSB first into shift reg.
//  STOP: sample at mid-bit. High: byte 0 -> store [15:8], index=1, IDLE (ready for
//   immediate start bit; transmitter sends byte 1 with no idle gap).
//   byte 1 -> DONE. Low: o_Frame_Err pulse, discard word, index=0, IDLE.
//  DONE: o_Rx_Word <= {hi,lo}, o_Rx_Valid pulse, o_Rx_Busy=0, index=0 -> IDLE.
//  Latency: o_Rx_Valid asserts 2 clocks after mid-stop sample of byte 1 (+2 sync).
//  o_Rx_Busy stays 1 between byte 0 and byte 1.
//  Counter width $clog2(CLKS_PER_BIT)+1; wrap never occurs (cleared at each bit end).
//  Reset mid-frame: immediate abort, no o_Rx_Valid, partial word lost.
//  Line held low (break): one frame error, then IDLE waits for a fresh falling edge.
// CONFIGURATION
//  `UART_RX_TIMEOUT_EN defined: in IDLE with index=1, count clocks; after
//   GAP_BITS*CLKS_PER_BIT clocks without a start -> o_Frame_Err pulse, index=0,
//   o_Rx_Busy=0, byte 0 discarded (resynchronises word alignment).
//  Not defined: receiver waits indefinitely for byte 1; only reset realigns.
// STRUCTURE
//  uart_defs.vh (shared with uart_tx): state encodings, UART_CLKS_PER_BIT macro/function.
//  Sub-module uart_rx_sync: 2-FF synchroniser, reset-to-1, plus falling-edge pulse.
//  Top: FSM, bit counter, byte index, shift register, output registers.
// TESTING (bench: CLOCK_RATE=1_000_000, BAUD_RATE=100_000 -> 10 clk/bit; uart_tx as driver)
//  1. uart_tx sends 16'hA55A -> one o_Rx_Valid, o_Rx_Word=16'hA55A, o_Frame_Err never.
//  2. Back-to-back words 16'h0001, 16'hFFFE -> two pulses, correct words in order.
//  3. 3-clk low glitch on idle line -> no state change past START, no valid/error.
//  4. Byte 1 stop bit forced low -> o_Frame_Err pulse, no o_Rx_Valid, word unchanged.
//  5. i_rst high during DATA of byte 0 -> outputs 0 immediately; next 16'h1234 clean.
//  6. TIMEOUT_EN: send byte 0 only, wait 40 clk -> o_Frame_Err; then 16'hBEEF received.

Source files
------------

// File: rtl/uart_rx_word_pkg.sv
// uart_rx_word_pkg: shared receiver state encoding and bit-period helper
package uart_rx_word_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} rx_state_t;
  function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction
endpackage

// File: rtl/uart_rx_word_sync.sv
// uart_rx_word_sync: 2-FF synchroniser (reset to idle-high) with falling-edge pulse
// ports: clk, rst (async high), din (raw line) -> dout (synchronised), fall (1->0 pulse)
module uart_rx_word_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);
  logic [2:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '1;
    else sr <= {sr[1:0], din};
  assign dout = sr[1];
  assign fall = sr[2] & ~sr[1];
endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: deserialises two back-to-back 8N1 frames (high byte first) into a 16-bit word
// ports: i_clk, i_rst (async high), i_Rx_Serial (idle high) -> o_Rx_Word, o_Rx_Valid (pulse),
//        o_Rx_Busy, o_Frame_Err (pulse)
// option: define UART_RX_TIMEOUT_EN to drop a lone high byte after GAP_BITS idle bit periods
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int BAUD_RATE  = 115_200,
  parameter int CLOCK_RATE = 27_000_000,
  parameter int GAP_BITS   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_Rx_Serial,
  output logic [15:0] o_Rx_Word,
  output logic        o_Rx_Valid,
  output logic        o_Rx_Busy,
  output logic        o_Frame_Err
);
  localparam int CPB = clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic idx, rx, fall;
  logic [7:0] hi, sh;
`ifdef UART_RX_TIMEOUT_EN
  localparam int GW = $clog2(GAP_BITS * CPB) + 1;
  localparam logic [GW-1:0] GAP_END = GW'(GAP_BITS * CPB - 1);
  logic [GW-1:0] gap;
`endif
  uart_rx_word_sync u_sync (.clk(i_clk), .rst(i_rst), .din(i_Rx_Serial), .dout(rx), .fall(fall));
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      idx         <= 1'b0;
      hi          <= '0;
      sh          <= '0;
      o_Rx_Word   <= '0;
      o_Rx_Valid  <= 1'b0;
      o_Rx_Busy   <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      gap         <= '0;
`endif
    end else begin
      o_Rx_Valid  <= 1'b0;
      o_Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (fall) begin
            state     <= START;
            o_Rx_Busy <= 1'b1;
          end
`ifdef UART_RX_TIMEOUT_EN
          // a high byte with no low byte following in time is dropped to realign words
          gap <= (fall || !idx) ? '0 : gap + 1'b1;
          if (!fall && idx && gap == GAP_END) begin
            o_Frame_Err <= 1'b1;
            o_Rx_Busy   <= 1'b0;
            idx         <= 1'b0;
            gap         <= '0;
          end
`endif
        end
        START:
          if (cnt == HALF) begin
            cnt <= '0;
            // false start keeps any stored high byte, so busy tracks the byte index
            if (rx) begin
              state     <= IDLE;
              o_Rx_Busy <= idx;
            end else state <= DATA;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == FULL) begin
            cnt     <= '0;
            sh      <= {rx, sh[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == FULL) begin
            cnt <= '0;
            if (!rx) begin
              o_Frame_Err <= 1'b1;
              o_Rx_Busy   <= 1'b0;
              idx         <= 1'b0;
              state       <= IDLE;
            end else if (idx) state <= DONE;
            else begin
              hi    <= sh;
              idx   <= 1'b1;
              state <= IDLE;
            end
          end else cnt <= cnt + 1'b1;
        DONE: begin
          o_Rx_Word  <= {hi, sh};
          o_Rx_Valid <= 1'b1;
          o_Rx_Busy  <= 1'b0;
          idx        <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
